// File: rtl/mac_array_pkg.sv
// Shared definitions for the MAC array sequencer: instruction codes, FSM states
// and phase-counter sizing.
package mac_array_pkg;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_EXEC,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  // Wide enough for k_len and for the ROW+COL-1 flush count, plus one spare bit.
  function automatic int cnt_bw(input int klen_bw, input int row, input int col);
    int flush_bw;
    flush_bw = $clog2(row + col);
    return ((klen_bw > flush_bw) ? klen_bw : flush_bw) + 1;
  endfunction

  localparam int CNT_BW = cnt_bw(8, 8, 8);

endpackage

// File: rtl/mac_array_seq_inst_skew.sv
// ROW-deep 2-bit shift chain: row 0 is the base instruction, row r lags it by r cycles.
module inst_skew
  import mac_array_pkg::*;
#(
  parameter int ROW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       inst_i,
  output logic [2*ROW-1:0] inst_row_o
);

  logic [1:0] skew_q [1:ROW-1];

  // NOTE: the skew chain is reset so that no stale instruction leaks into the
  // array after an aborted pass; it is only ROW-1 entries, not a storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < ROW; r++) skew_q[r] <= INST_IDLE;
    end else begin
      skew_q[1] <= inst_i;
      for (int r = 2; r < ROW; r++) skew_q[r] <= skew_q[r-1];
    end
  end

  assign inst_row_o[1:0] = inst_i;

  for (genvar g = 1; g < ROW; g++) begin : g_row
    assign inst_row_o[2*g+1:2*g] = skew_q[g];
  end

endmodule

// File: rtl/mac_array_seq.sv
// Sequencer for a ROW x COL MAC array (WS and OS passes, OS result drain).
// Optional busy-cycle counter enabled by defining MAC_ARRAY_SEQ_PERF_EN.
module mac_array_seq
  import mac_array_pkg::*;
#(
  parameter int ROW     = 8,
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int KLEN_BW = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         mode,
  input  logic [KLEN_BW-1:0]           k_len,
  output logic                         busy,
  output logic                         done,
  output logic                         acc_clr,
  output logic [2*ROW-1:0]             inst_row,
  input  logic [PSUM_BW*COL*ROW-1:0]   os_in,
  output logic [PSUM_BW*COL-1:0]       drain_data,
  output logic [$clog2(ROW)-1:0]       drain_row,
  output logic                         drain_valid,
  input  logic                         drain_ready
`ifdef MAC_ARRAY_SEQ_PERF_EN
  ,
  output logic [31:0]                  perf_cycles
`endif
);

  localparam int RW = $clog2(ROW);
  localparam int CW = cnt_bw(KLEN_BW, ROW, COL);
  localparam int SW = PSUM_BW * COL;

  localparam logic [CW-1:0] LOAD_LAST  = CW'(ROW - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(ROW + COL - 2);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROW - 1);

  seq_state_t         state_q, state_d;
  logic               mode_q, mode_d;
  logic [KLEN_BW-1:0] klen_q, klen_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RW-1:0]      drain_row_q, drain_row_d;
  logic [1:0]         inst_base;

  logic [CW-1:0] exec_last;
  logic          klen_zero;

  assign klen_zero = (klen_q == '0);
  assign exec_last = CW'(klen_q) - CW'(1);

  // NOTE: every state register uses non-blocking assignment so all of them
  // update together from the values seen before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      klen_q      <= '0;
      cnt_q       <= '0;
      drain_row_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      klen_q      <= klen_d;
      cnt_q       <= cnt_d;
      drain_row_q <= drain_row_d;
    end
  end

  // NOTE: each variable gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    klen_d      = klen_q;
    cnt_d       = cnt_q + CW'(1);
    drain_row_d = drain_row_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          mode_d      = mode;
          klen_d      = k_len;
          drain_row_d = '0;
          state_d     = mode ? S_CLR : S_LOAD;
        end
      end
      S_CLR: begin
        cnt_d   = '0;
        state_d = klen_zero ? S_FLUSH : S_EXEC;
      end
      S_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = klen_zero ? S_FLUSH : S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == exec_last) begin
          cnt_d   = '0;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          cnt_d   = '0;
          state_d = mode_q ? S_DRAIN : S_DONE;
        end
      end
      S_DRAIN: begin
        cnt_d = '0;
        if (drain_ready) begin
          if (drain_row_q == ROW_LAST) begin
            drain_row_d = '0;
            state_d     = S_DONE;
          end else begin
            drain_row_d = drain_row_q + RW'(1);
          end
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    inst_base = INST_IDLE;
    if (state_q == S_LOAD) inst_base = INST_LOAD;
    if (state_q == S_EXEC) inst_base = INST_EXEC;
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign acc_clr     = (state_q == S_CLR);
  assign drain_valid = (state_q == S_DRAIN);
  assign drain_row   = drain_row_q;

  inst_skew #(.ROW(ROW)) u_inst_skew (
    .clk        (clk),
    .rst_n      (reset),
    .inst_i     (inst_base),
    .inst_row_o (inst_row)
  );

  logic [SW-1:0] os_rows [ROW];
  for (genvar g = 0; g < ROW; g++) begin : g_os_row
    assign os_rows[g] = os_in[g*SW +: SW];
  end
  assign drain_data = os_rows[drain_row_q];

`ifdef MAC_ARRAY_SEQ_PERF_EN
  logic [31:0] perf_q;

  // Restarts with every accepted pass and sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      perf_q <= '0;
    end else if (busy && perf_q != '1) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  // Busy-cycle counter not built in this configuration.
`endif

endmodule

// File: tb/tb_mac_array_seq.sv
// Directed self-checking bench for mac_array_seq (default 8x8 configuration).
module tb_mac_array_seq;

  localparam int ROW     = 8;
  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int KLEN_BW = 8;
  localparam int SW      = PSUM_BW * COL;

  logic                       clk = 1'b0;
  logic                       reset = 1'b0;
  logic                       start = 1'b0;
  logic                       mode = 1'b0;
  logic [KLEN_BW-1:0]         k_len = '0;
  logic                       busy, done, acc_clr, drain_valid;
  logic [2*ROW-1:0]           inst_row;
  logic [PSUM_BW*COL*ROW-1:0] os_in;
  logic [SW-1:0]              drain_data;
  logic [2:0]                 drain_row;
  logic                       drain_ready = 1'b1;
`ifdef MAC_ARRAY_SEQ_PERF_EN
  logic [31:0]                perf_cycles;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  mac_array_seq #(
    .ROW(ROW), .COL(COL), .PSUM_BW(PSUM_BW), .KLEN_BW(KLEN_BW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .k_len       (k_len),
    .busy        (busy),
    .done        (done),
    .acc_clr     (acc_clr),
    .inst_row    (inst_row),
    .os_in       (os_in),
    .drain_data  (drain_data),
    .drain_row   (drain_row),
    .drain_valid (drain_valid),
    .drain_ready (drain_ready)
`ifdef MAC_ARRAY_SEQ_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Row r, column c of the array holds 16'hA000 + 16*r + c.
  function automatic logic [SW-1:0] row_pat(input int r);
    logic [SW-1:0] v;
    for (int c = 0; c < COL; c++) v[c*PSUM_BW +: PSUM_BW] = 16'(16'hA000 + r * 16 + c);
    return v;
  endfunction

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Start is sampled at edge 0; returns #1 into cycle 1 with inputs scrambled.
  task automatic begin_pass(input logic m, input logic [KLEN_BW-1:0] k);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    k_len = k;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = ~m;
    k_len = 8'hC8;
    cyc   = 1;
  endtask

  initial begin
    for (int r = 0; r < ROW; r++) os_in[r*SW +: SW] = row_pat(r);

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_acc_clr", acc_clr, 0);
    check("rst_drain_valid", drain_valid, 0);
    check("rst_drain_row", drain_row, 0);
    check("rst_inst_row", inst_row, 0);
    @(negedge clk);
    reset = 1'b1;

    // WS, k_len = 3
    begin_pass(1'b0, 8'd3);
    for (int i = 0; i < 27; i++) begin
      check("ws3_inst0", inst_row[1:0], (cyc <= 8) ? 2'b01 : (cyc <= 11) ? 2'b10 : 2'b00);
      check("ws3_inst7", inst_row[15:14],
            (cyc >= 8 && cyc <= 15) ? 2'b01 : (cyc >= 16 && cyc <= 18) ? 2'b10 : 2'b00);
      check("ws3_busy", busy, 1);
      check("ws3_done", done, cyc == 27);
      check("ws3_acc_clr", acc_clr, 0);
      check("ws3_drain_valid", drain_valid, 0);
      tick();
    end
    check("ws3_idle_busy", busy, 0);
    check("ws3_idle_done", done, 0);
`ifdef MAC_ARRAY_SEQ_PERF_EN
    check("ws3_perf", perf_cycles, 27);
`endif

    // OS, k_len = 5, consumer always ready
    begin_pass(1'b1, 8'd5);
    for (int i = 0; i < 30; i++) begin
      check("os5_acc_clr", acc_clr, cyc == 1);
      check("os5_inst0", inst_row[1:0], (cyc >= 2 && cyc <= 6) ? 2'b10 : 2'b00);
      check("os5_drain_valid", drain_valid, cyc >= 22 && cyc <= 29);
      if (cyc >= 22 && cyc <= 29) begin
        check("os5_drain_row", drain_row, cyc - 22);
        check("os5_drain_data", drain_data, row_pat(cyc - 22));
      end
      check("os5_done", done, cyc == 30);
      tick();
    end
    check("os5_idle_busy", busy, 0);

    // OS, k_len = 5, consumer stalls 4 cycles on row 3
    begin_pass(1'b1, 8'd5);
    for (int i = 0; i < 34; i++) begin
      int exp_row;
      if (cyc == 25) drain_ready = 1'b0;
      if (cyc == 29) drain_ready = 1'b1;
      exp_row = (cyc <= 24) ? cyc - 22 : (cyc <= 29) ? 3 : cyc - 26;
      check("stall_drain_valid", drain_valid, cyc >= 22 && cyc <= 33);
      if (cyc >= 22 && cyc <= 33) begin
        check("stall_drain_row", drain_row, exp_row);
        check("stall_drain_data", drain_data, row_pat(exp_row));
      end
      check("stall_done", done, cyc == 34);
      tick();
    end
    check("stall_idle_busy", busy, 0);

    // WS, k_len = 0: EXEC skipped
    begin_pass(1'b0, 8'd0);
    for (int i = 0; i < 24; i++) begin
      check("ws0_inst0", inst_row[1:0], (cyc <= 8) ? 2'b01 : 2'b00);
      check("ws0_inst7", inst_row[15:14], (cyc >= 8 && cyc <= 15) ? 2'b01 : 2'b00);
      check("ws0_busy", busy, 1);
      check("ws0_done", done, cyc == 24);
      tick();
    end
    check("ws0_idle_busy", busy, 0);

    // Asynchronous reset in cycle 10 of an OS pass
    begin_pass(1'b1, 8'd5);
    for (int i = 0; i < 9; i++) begin
      check("abort_pre_done", done, 0);
      tick();
    end
    check("abort_pre_inst_nonzero", inst_row != '0, 1);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_acc_clr", acc_clr, 0);
    check("abort_drain_valid", drain_valid, 0);
    check("abort_drain_row", drain_row, 0);
    check("abort_inst_row", inst_row, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("abort_hold_busy", busy, 0);
      check("abort_hold_inst_row", inst_row, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      check("abort_after_busy", busy, 0);
      check("abort_after_done", done, 0);
    end

    // WS, k_len = 3 with starts during busy and in the DONE cycle
    begin_pass(1'b0, 8'd3);
    for (int i = 0; i < 27; i++) begin
      if (cyc == 5) begin
        start = 1'b1;
        mode  = 1'b1;
        k_len = 8'd9;
      end
      if (cyc == 6) start = 1'b0;
      if (cyc == 27) start = 1'b1;
      check("ignore_inst0", inst_row[1:0], (cyc <= 8) ? 2'b01 : (cyc <= 11) ? 2'b10 : 2'b00);
      check("ignore_acc_clr", acc_clr, 0);
      check("ignore_done", done, cyc == 27);
      tick();
    end
    start = 1'b0;
    check("ignore_idle_busy", busy, 0);
    tick();
    check("ignore_idle_busy2", busy, 0);
`ifdef MAC_ARRAY_SEQ_PERF_EN
    check("ignore_perf", perf_cycles, 27);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
